// File: rtl/apb_pkg.sv
// Shared types for the APB master: FSM state encoding, command bundle and
// the wait-timer counter width helper.
// Ports: none (package).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // Counter must hold values 0..cycles; never narrower than 1 bit so a
  // disabled timeout (cycles == 0) still elaborates cleanly.
  function automatic int tmo_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared while the master is in SETUP, counts
// ACCESS cycles without pready, flags when the last permitted cycle is reached.
// Ports: i_clk/i_rst_n clock and async reset, i_clr clear, i_en count enable,
//        o_expire high while the count equals TIMEOUT_CYCLES-1 (never if 0).
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: one SETUP+ACCESS transfer per accepted command, with an address
// window check and an ACCESS timeout; response held until rsp_ready_i.
// Ports: cmd_* request (valid/ready), rsp_* response (valid/ready), timeout_o
//        abort pulse, reg_addr_low/high_i window, p* APB master signals.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk_i,
  input  logic                  prstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  timeout_o,
  input  logic [ADDR_WIDTH-1:0] reg_addr_low_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_high_i,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  apb_state_e            r_state;
  apb_state_e            w_next;
  logic                  r_out_en;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_timeout;

  logic w_in_window;
  logic w_accept;
  logic w_done;
  logic w_abort;
  logic w_expire;

  assign w_in_window = (cmd_addr_i >= reg_addr_low_i) && (cmd_addr_i <= reg_addr_high_i);
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  assign w_done      = (r_state == ACCESS) && pready_i;
  // pready on the limit cycle takes priority over the timeout.
  assign w_abort     = (r_state == ACCESS) && !pready_i && w_expire;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk   (pclk_i),
    .i_rst_n (prstn_i),
    .i_clr   (r_state == SETUP),
    .i_en    ((r_state == ACCESS) && !pready_i),
    .o_expire(w_expire)
  );

  // State register. r_out_en keeps cmd_ready_o low while reset is asserted
  // and rises on the first clock after release.
  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      r_state  <= IDLE;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_out_en <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_in_window ? SETUP : RESP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_done || w_abort) w_next = RESP;
      RESP:    if (rsp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    cmd_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      IDLE:    cmd_ready_o = r_out_en;
      SETUP:   psel_o      = 1'b1;
      ACCESS:  begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Command latch and response registers. Address/data are only written on
  // accept, so they stay stable through SETUP/ACCESS and linger in IDLE.
  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_abort;
      if (w_accept) begin
        r_pwrite <= cmd_write_i;
        r_paddr  <= cmd_addr_i;
        r_pwdata <= cmd_wdata_i;
        r_err    <= !w_in_window;
        r_rdata  <= '0;
      end
      if (w_done) begin
        r_err   <= pslverr_i;
        r_rdata <= (r_pwrite || pslverr_i) ? '0 : prdata_i;
      end
      if (w_abort) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign pwrite_o    = r_pwrite;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  logic        pclk = 1'b0;
  logic        prstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] win_lo, win_hi;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  always #5 pclk = ~pclk;

  apb_master_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk_i(pclk), .prstn_i(prstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .timeout_o(timeout),
    .reg_addr_low_i(win_lo), .reg_addr_high_i(win_hi),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Results of the last run_cmd.
  int          g_psel, g_acc, g_lat, g_valid, g_tmo, g_unst, g_cr, g_rpsel;
  logic        g_err;
  logic [31:0] g_rdata;

  // Issue one command from IDLE and play the slave: pready rises on ACCESS
  // cycle number waits+1. Outside ACCESS pready/pslverr are driven high to
  // show they are ignored there. The response is held for 'hold' extra cycles.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdat, input logic slverr,
                         input int hold);
    g_psel = 0; g_acc = 0; g_lat = -1; g_valid = 0; g_tmo = 0;
    g_unst = 0; g_cr = 0; g_rpsel = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5_A5A5;
    tick();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
    for (int i = 1; i <= 60; i++) begin
      if (timeout) g_tmo++;
      if (psel) begin
        g_psel++;
        if (paddr !== addr || pwrite !== wr || pwdata !== wdata) g_unst++;
      end
      if (penable) begin
        g_acc++;
        pready = (g_acc - 1 == waits);
        prdata = rdat;
        pslverr = slverr;
      end else begin
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5_A5A5;
      end
      if (rsp_valid) begin
        g_lat = i;
        break;
      end
      tick();
    end
    if (g_lat < 0) begin
      chk("rsp_valid_within_bound", rsp_valid, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end else begin
      g_err = rsp_err;
      g_rdata = rsp_rdata;
      for (int h = 0; h <= hold; h++) begin
        if (rsp_valid) g_valid++;
        if (cmd_ready) g_cr++;
        if (psel || penable) g_rpsel++;
        if (rsp_err !== g_err || rsp_rdata !== g_rdata) g_unst++;
        if (h > 0 && timeout) g_tmo++;
        rsp_ready = (h == hold);
        tick();
      end
      rsp_ready = 1'b0;
    end
  endtask

  task automatic chk_res(input string t, input int e_psel, input int e_acc, input int e_lat,
                         input logic e_err, input logic [31:0] e_rdata, input int e_tmo,
                         input int hold);
    chk({t, ".psel_cycles"}, g_psel, e_psel);
    chk({t, ".access_cycles"}, g_acc, e_acc);
    chk({t, ".rsp_latency"}, g_lat, e_lat);
    chk({t, ".rsp_err"}, g_err, e_err);
    chk({t, ".rsp_rdata"}, g_rdata, e_rdata);
    chk({t, ".timeout_pulses"}, g_tmo, e_tmo);
    chk({t, ".rsp_valid_cycles"}, g_valid, hold + 1);
    chk({t, ".cmd_ready_in_resp"}, g_cr, 0);
    chk({t, ".apb_active_in_resp"}, g_rpsel, 0);
    chk({t, ".unstable"}, g_unst, 0);
    chk({t, ".cmd_ready_after"}, cmd_ready, 1'b1);
    chk({t, ".rsp_valid_after"}, rsp_valid, 1'b0);
  endtask

  logic [31:0] bnd_addr [4] = '{32'h3F, 32'h40, 32'h80, 32'h81};
  logic        bnd_err  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int          bnd_lat  [4] = '{1, 3, 3, 1};
  int          bnd_psel [4] = '{0, 2, 2, 0};
  int          idle_bad;

  initial begin
    prstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; win_lo = 32'h0; win_hi = 32'hFF;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    chk("rst.cmd_ready", cmd_ready, 1'b0);
    chk("rst.psel", psel, 1'b0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    @(negedge pclk);
    prstn = 1'b1;
    tick();
    chk("idle.cmd_ready", cmd_ready, 1'b1);
    chk("idle.apb", {psel, penable, pwrite, paddr, pwdata}, '0);
    chk("idle.rsp", {rsp_valid, rsp_err, timeout, rsp_rdata}, '0);

    // Zero-wait write
    run_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);
    chk_res("wr0", 2, 1, 3, 1'b0, 32'h0, 0, 0);
    chk("wr0.paddr_retained", paddr, 32'h10);

    // Read with 3 wait states
    run_cmd(1'b0, 32'h20, 32'h0, 3, 32'h1234_5678, 1'b0, 0);
    chk_res("rd3", 5, 4, 6, 1'b0, 32'h1234_5678, 0, 0);

    // Window miss: no APB activity
    run_cmd(1'b0, 32'h100, 32'h0, 0, 32'h5555_5555, 1'b0, 0);
    chk_res("miss", 0, 0, 1, 1'b1, 32'h0, 0, 0);

    // Timeout: 8 ACCESS cycles, one-cycle pulse
    run_cmd(1'b0, 32'h30, 32'h0, 1000, 32'h7777_7777, 1'b0, 1);
    chk_res("tmo", 9, 8, 10, 1'b1, 32'h0, 1, 1);

    // pready on the limit cycle wins
    run_cmd(1'b0, 32'h34, 32'h0, 7, 32'hCAFE_F00D, 1'b0, 0);
    chk_res("lim", 9, 8, 10, 1'b0, 32'hCAFE_F00D, 0, 0);

    // Slave error, response back-pressured for 5 cycles
    run_cmd(1'b1, 32'h40, 32'h0BAD_CAFE, 0, 32'h0, 1'b1, 5);
    chk_res("slverr", 2, 1, 3, 1'b1, 32'h0, 0, 5);

    // Window boundaries (inclusive)
    win_lo = 32'h40; win_hi = 32'h80;
    for (int k = 0; k < 4; k++) begin
      run_cmd(1'b0, bnd_addr[k], 32'h0, 0, 32'h9000_0000 | bnd_addr[k], 1'b0, 0);
      chk_res($sformatf("bnd%0d", k), bnd_psel[k], bnd_psel[k] / 2, bnd_lat[k], bnd_err[k],
              bnd_err[k] ? 32'h0 : (32'h9000_0000 | bnd_addr[k]), 0, 0);
    end
    win_lo = 32'h0; win_hi = 32'hFF;

    // Reset during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24;
    pready = 1'b0; pslverr = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rstmid.in_access", penable, 1'b1);
    #2 prstn = 1'b0;
    #1;
    chk("rstmid.async_drop", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge pclk);
    prstn = 1'b1;
    pready = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!cmd_ready || rsp_valid || psel) idle_bad++;
    end
    chk("rstmid.no_stale_rsp", idle_bad, 0);
    run_cmd(1'b1, 32'h10, 32'h1357_9BDF, 0, 32'h0, 1'b0, 0);
    chk_res("post_rst", 2, 1, 3, 1'b0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
